// File: rtl/fetch_pair_unit.sv
// Fetch front end: PC generation, paired I-cache fetch and packet push.
// Ports: clk/rst, flush/new_pc redirect, stall from the instruction buffer,
//   bpu_pc/pred_taken/pred_target predictor, icache_* request/response,
//   inst_valid/pc1/pc2/inst1/inst2/pred_addr/is_exception/exception_cause.
module fetch_pair_unit #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter logic [6:0]  ADEF_CAUSE = 7'h08
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        stall,
   output logic [31:0] bpu_pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   output logic        icache_req,
   output logic [31:0] icache_addr,
   input  logic        icache_ready,
   input  logic        icache_rvalid,
   input  logic [31:0] icache_inst1,
   input  logic [31:0] icache_inst2,
   output logic        inst_valid,
   output logic [31:0] pc1,
   output logic [31:0] pc2,
   output logic [31:0] inst1,
   output logic [31:0] inst2,
   output logic [31:0] pred_addr,
   output logic        is_exception,
   output logic [6:0]  exception_cause
);

   typedef enum logic [2:0] {
      ST_REQ,
      ST_WAIT,
      ST_OUT,
      ST_DROP,
      ST_EXC
   } state_t;

   typedef struct packed {
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic [31:0] inst1;
      logic [31:0] inst2;
      logic [31:0] pred;
      logic        exc;
      logic [6:0]  cause;
   } pkt_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] npc_q, npc_d;
   pkt_t        pkt_q, pkt_d;

   logic aligned;
   logic req;
   logic accept;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      pkt_d   = pkt_q;

      aligned = (pc_q[1:0] == 2'b00);
      // Reset gates the request so nothing is issued while the cache resets.
      req     = (state_q == ST_REQ) && aligned && !rst;
      accept  = req && icache_ready;

      if (flush) begin
         pc_d = new_pc;
         unique case (state_q)
            ST_WAIT: state_d = icache_rvalid ? ST_REQ : ST_DROP;
            ST_REQ:  state_d = accept ? ST_DROP : ST_REQ;
            ST_DROP: state_d = icache_rvalid ? ST_REQ : ST_DROP;
            default: state_d = ST_REQ;
         endcase
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (!aligned) begin
                  pkt_d.pc1   = pc_q;
                  pkt_d.pc2   = pc_q + 32'd4;
                  pkt_d.inst1 = '0;
                  pkt_d.inst2 = '0;
                  pkt_d.pred  = pc_q + 32'd8;
                  pkt_d.exc   = 1'b1;
                  pkt_d.cause = ADEF_CAUSE;
                  state_d     = ST_OUT;
               end else if (accept) begin
                  npc_d   = pred_taken ? pred_target : pc_q + 32'd8;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (icache_rvalid) begin
                  pkt_d.pc1   = pc_q;
                  pkt_d.pc2   = pc_q + 32'd4;
                  pkt_d.inst1 = icache_inst1;
                  pkt_d.inst2 = icache_inst2;
                  pkt_d.pred  = npc_q;
                  pkt_d.exc   = 1'b0;
                  pkt_d.cause = '0;
                  state_d     = ST_OUT;
               end
            end
            ST_OUT: begin
               if (!stall) begin
                  if (pkt_q.exc) begin
                     state_d = ST_EXC;
                  end else begin
                     pc_d    = npc_q;
                     state_d = ST_REQ;
                  end
               end
            end
            ST_DROP: begin
               if (icache_rvalid) state_d = ST_REQ;
            end
            ST_EXC: state_d = ST_EXC;
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         npc_q   <= '0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         pkt_q   <= pkt_d;
      end
   end

   assign bpu_pc          = pc_q;
   assign icache_addr     = pc_q;
   assign icache_req      = req;
   assign inst_valid      = (state_q == ST_OUT) && !stall && !flush && !rst;
   assign pc1             = pkt_q.pc1;
   assign pc2             = pkt_q.pc2;
   assign inst1           = pkt_q.inst1;
   assign inst2           = pkt_q.inst2;
   assign pred_addr       = pkt_q.pred;
   assign is_exception    = pkt_q.exc;
   assign exception_cause = pkt_q.cause;

endmodule

// File: tb/tb_fetch_pair_unit.sv
// Directed bench for fetch_pair_unit with a small I-cache model.
// Ports: none; drives the DUT and prints CHECKS/ERRORS summary.
module tb_fetch_pair_unit;

   logic        clk = 1'b0;
   logic        rst, flush, stall;
   logic [31:0] new_pc;
   logic [31:0] bpu_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_ready, icache_rvalid;
   logic [31:0] icache_inst1, icache_inst2;
   logic        inst_valid;
   logic [31:0] pc1, pc2, inst1, inst2, pred_addr;
   logic        is_exception;
   logic [6:0]  exception_cause;

   fetch_pair_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall(stall),
      .bpu_pc(bpu_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .icache_req(icache_req), .icache_addr(icache_addr),
      .icache_ready(icache_ready), .icache_rvalid(icache_rvalid),
      .icache_inst1(icache_inst1), .icache_inst2(icache_inst2),
      .inst_valid(inst_valid), .pc1(pc1), .pc2(pc2),
      .inst1(inst1), .inst2(inst2), .pred_addr(pred_addr),
      .is_exception(is_exception), .exception_cause(exception_cause)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // cache model state
   bit          pend;
   int          cnt;
   int          lat;
   logic [31:0] paddr;
   logic [31:0] taken_pc, taken_tgt;

   // per-cycle samples
   logic        s_req, s_valid, acc;
   logic [31:0] s_addr, s_pc1;
   int          cyc_n;

   logic [31:0] q_pc1[$], q_pc2[$], q_i1[$], q_i2[$], q_pred[$];
   logic [31:0] q_exc[$], q_cause[$], q_acc[$];
   int          q_cyc[$];

   task automatic clear_log();
      q_pc1.delete(); q_pc2.delete(); q_i1.delete(); q_i2.delete();
      q_pred.delete(); q_exc.delete(); q_cause.delete();
      q_acc.delete(); q_cyc.delete();
      cyc_n = 0;
   endtask

   // One clock cycle; inputs are set by the caller just after negedge.
   task automatic cyc();
      icache_rvalid = pend && (cnt == 0);
      icache_inst1  = icache_rvalid ? (paddr ^ 32'ha5a50000) : 32'h0;
      icache_inst2  = icache_rvalid ? ((paddr + 32'd4) ^ 32'ha5a50000) : 32'h0;
      #1;
      pred_taken  = (bpu_pc == taken_pc);
      pred_target = taken_tgt;
      #1;
      s_req   = icache_req;
      s_addr  = icache_addr;
      s_valid = inst_valid;
      s_pc1   = pc1;
      acc     = icache_req && icache_ready;
      if (s_valid) begin
         q_pc1.push_back(pc1);
         q_pc2.push_back(pc2);
         q_i1.push_back(inst1);
         q_i2.push_back(inst2);
         q_pred.push_back(pred_addr);
         q_exc.push_back(32'(is_exception));
         q_cause.push_back(32'(exception_cause));
         q_cyc.push_back(cyc_n);
      end
      if (acc) q_acc.push_back(s_addr);
      @(posedge clk);
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (icache_rvalid) pend = 1'b0;
         else if (pend && cnt > 0) cnt--;
         if (acc) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = s_addr;
         end
      end
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic chk_push(input string tag, input int i,
                           input logic [31:0] e_pc1,
                           input logic [31:0] e_pred);
      if (i >= q_pc1.size()) begin
         chk({tag, "_missing"}, 32'(q_pc1.size()), 32'(i + 1));
      end else begin
         chk({tag, "_pc1"}, q_pc1[i], e_pc1);
         chk({tag, "_pc2"}, q_pc2[i], e_pc1 + 32'd4);
         chk({tag, "_pred"}, q_pred[i], e_pred);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 1'b0; new_pc = '0;
      pred_taken = 1'b0; pred_target = '0;
      icache_ready = 1'b1; icache_rvalid = 1'b0;
      icache_inst1 = '0; icache_inst2 = '0;
      pend = 1'b0; cnt = 0; lat = 1; paddr = '0;
      taken_pc = 32'hffffffff; taken_tgt = '0;
      cyc_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // reset cycle and reset values
      cyc();
      chk("rst_req", 32'(s_req), 32'd0);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_addr", icache_addr, 32'h1c000000);
      chk("rst_pc1", pc1, 32'h0);
      chk("rst_pc2", pc2, 32'h0);
      chk("rst_pred", pred_addr, 32'h0);
      chk("rst_exc", 32'(is_exception), 32'd0);
      chk("rst_cause", 32'(exception_cause), 32'd0);
      rst = 1'b0;

      // sequential fetch
      clear_log();
      cyc();
      chk("seq_first_req", 32'(s_req), 32'd1);
      repeat (8) cyc();
      chk("seq_count", 32'(q_pc1.size()), 32'd3);
      chk_push("seq0", 0, 32'h1c000000, 32'h1c000008);
      chk_push("seq1", 1, 32'h1c000008, 32'h1c000010);
      chk_push("seq2", 2, 32'h1c000010, 32'h1c000018);
      if (q_cyc.size() == 3) begin
         chk("seq_cyc0", 32'(q_cyc[0]), 32'd2);
         chk("seq_cyc1", 32'(q_cyc[1]), 32'd5);
         chk("seq_cyc2", 32'(q_cyc[2]), 32'd8);
         chk("seq_i1", q_i1[0], 32'hb9a50000);
         chk("seq_i2", q_i2[0], 32'hb9a50004);
         chk("seq_exc", q_exc[0], 32'd0);
      end

      // taken prediction, after a fresh reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      taken_pc = 32'h1c000008; taken_tgt = 32'h1c000100;
      clear_log();
      repeat (9) cyc();
      taken_pc = 32'hffffffff;
      chk("tkn_count", 32'(q_pc1.size()), 32'd3);
      chk_push("tkn0", 0, 32'h1c000000, 32'h1c000008);
      chk_push("tkn1", 1, 32'h1c000008, 32'h1c000100);
      chk_push("tkn2", 2, 32'h1c000100, 32'h1c000108);
      if (q_acc.size() >= 3) chk("tkn_acc", q_acc[2], 32'h1c000100);
      else chk("tkn_acc_missing", 32'(q_acc.size()), 32'd3);

      // stall backpressure
      clear_log();
      repeat (2) cyc();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stl_valid", 32'(s_valid), 32'd0);
         chk("stl_pc1", s_pc1, 32'h1c000108);
      end
      stall = 1'b0;
      cyc();
      chk("stl_release", 32'(s_valid), 32'd1);
      chk("stl_count", 32'(q_pc1.size()), 32'd1);
      chk_push("stl", 0, 32'h1c000108, 32'h1c000110);

      // flush while waiting on a slow response
      clear_log();
      lat = 4;
      cyc();
      lat = 1;
      chk("fw_acc", 32'(q_acc.size()), 32'd1);
      flush = 1'b1; new_pc = 32'h1c002000;
      cyc();
      flush = 1'b0;
      cyc();
      chk("fw_drop_req", 32'(s_req), 32'd0);
      repeat (2) cyc();
      cyc();
      chk("fw_req", 32'(s_req), 32'd1);
      chk("fw_addr", s_addr, 32'h1c002000);
      repeat (2) cyc();
      chk("fw_count", 32'(q_pc1.size()), 32'd1);
      chk_push("fw", 0, 32'h1c002000, 32'h1c002008);
      if (q_i1.size() == 1) chk("fw_i1", q_i1[0], 32'hb9a52000);

      // flush and rvalid together in WAIT
      clear_log();
      cyc();
      flush = 1'b1; new_pc = 32'h1c003000;
      cyc();
      flush = 1'b0;
      cyc();
      chk("fr_req", 32'(s_req), 32'd1);
      chk("fr_addr", s_addr, 32'h1c003000);
      chk("fr_nopush", 32'(q_pc1.size()), 32'd0);
      repeat (2) cyc();
      chk("fr_count", 32'(q_pc1.size()), 32'd1);
      chk_push("fr", 0, 32'h1c003000, 32'h1c003008);

      // misaligned redirect
      clear_log();
      icache_ready = 1'b0;
      flush = 1'b1; new_pc = 32'h1c000002;
      cyc();
      flush = 1'b0;
      icache_ready = 1'b1;
      cyc();
      chk("mis_req", 32'(s_req), 32'd0);
      chk("mis_valid0", 32'(s_valid), 32'd0);
      cyc();
      chk("mis_valid1", 32'(s_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("mis_idle_req", 32'(s_req), 32'd0);
      end
      chk("mis_count", 32'(q_pc1.size()), 32'd1);
      chk("mis_acc", 32'(q_acc.size()), 32'd0);
      chk_push("mis", 0, 32'h1c000002, 32'h1c00000a);
      if (q_pc1.size() == 1) begin
         chk("mis_exc", q_exc[0], 32'd1);
         chk("mis_cause", q_cause[0], 32'h08);
         chk("mis_i1", q_i1[0], 32'h0);
         chk("mis_i2", q_i2[0], 32'h0);
      end
      flush = 1'b1; new_pc = 32'h1c000000;
      cyc();
      flush = 1'b0;
      cyc();
      chk("mis_exit_req", 32'(s_req), 32'd1);
      chk("mis_exit_addr", s_addr, 32'h1c000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
